fetch_stall_ctrl: RTL and testbench

Fetch-side consumer of the hazard detection unit's stall outputs. Owns the PC register and the IF/ID pipeline register, and honours pc_stall and IF_ID_stall. Also handles branch/jump redirects and multi-cycle instruction-memory responses. Sits between instruction memory and the ID stage of the 5-stage MIPS pipeline.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_stall_ctrl_if.sv | 29 ++
 rtl/sat_counter.sv | 37 +++
 rtl/fetch_stall_ctrl.sv | 143 ++++++++++++++
 tb/tb_fetch_stall_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stall controller
//   state encoding, NOP instruction word and PC increment used by fetch_stall_ctrl
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          PC_INC    = 4;

endpackage

// File: rtl/fetch_stall_ctrl_if.sv
// rtl/fetch_stall_ctrl_if.sv - instruction memory request/response interface
//   imem_addr  : fetch address (master -> slave)
//   imem_req   : fetch request (master -> slave)
//   imem_ready : imem_rdata valid for the current request (slave -> master)
//   imem_rdata : fetched instruction word (slave -> master)
interface fetch_stall_ctrl_if #(
    parameter int ADDR_W = 32
);

    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_ready;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter, built only with STALL_PERF_CNT_EN
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset, clears count
//   inc   : increment request this cycle
//   count : current value, holds at all-ones
`ifdef STALL_PERF_CNT_EN
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/fetch_stall_ctrl.sv
// rtl/fetch_stall_ctrl.sv - PC and IF/ID register owner honouring hazard stalls, redirects and slow imem
//   clk, reset           : pipeline clock, asynchronous active-high reset
//   pc_stall, IF_ID_stall: hold PC / hold IF/ID (load-use hazard)
//   redirect, redirect_pc: branch/jump resolved in ID, flush fetch
//   imem                 : instruction memory interface (master side)
//   pc, if_id_*          : current PC and IF/ID register contents
//   perf_*               : performance counters, live only with STALL_PERF_CNT_EN defined
module fetch_stall_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pc_stall,
    input  logic                  IF_ID_stall,
    input  logic                  redirect,
    input  logic [ADDR_W-1:0]     redirect_pc,
    fetch_stall_ctrl_if.master    imem,
    output logic [ADDR_W-1:0]     pc,
    output logic [31:0]           if_id_instr,
    output logic [ADDR_W-1:0]     if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic [CNT_W-1:0]      perf_hazard_stalls,
    output logic [CNT_W-1:0]      perf_mem_waits,
    output logic [CNT_W-1:0]      perf_flushes
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] ppc4_q, ppc4_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_plus4;

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_plus4 = pc_q + ADDR_W'(PC_INC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ppc4_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ppc4_q  <= ppc4_d;
            valid_q <= valid_d;
        end
    end

    // Priority: redirect > orphan drain > memory not ready > stall > advance.
    // A bubble clears instr/valid and leaves if_id_pc_plus4 as it was.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ppc4_d  = ppc4_q;
        valid_d = valid_q;
        if (redirect) begin
            pc_d    = redirect_pc;
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            // An older request still in flight would return the wrong word.
            state_d = ((state_q != FETCH) && !imem.imem_ready) ? SQUASH : FETCH;
        end else if (state_q == SQUASH) begin
            if (imem.imem_ready) begin
                state_d = FETCH;
            end
            if (!IF_ID_stall) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end else if (!imem.imem_ready) begin
            state_d = WAIT;
            if (!IF_ID_stall) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end else begin
            state_d = FETCH;
            if (!pc_stall) begin
                pc_d = pc_plus4;
            end
            if (!IF_ID_stall) begin
                if (pc_stall) begin
                    // Word is refetched next cycle, so it must not enter ID now.
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else begin
                    instr_d = imem.imem_rdata;
                    ppc4_d  = pc_plus4;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        imem.imem_req  = !reset;
        imem.imem_addr = pc_q;
        pc             = pc_q;
        if_id_instr    = instr_q;
        if_id_pc_plus4 = ppc4_q;
        if_id_valid    = valid_q;
    end

`ifdef STALL_PERF_CNT_EN
    logic in_wait;
    assign in_wait = (state_q == WAIT) || (state_q == SQUASH);

    sat_counter #(.CNT_W(CNT_W)) u_hazard_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (pc_stall),
        .count (perf_hazard_stalls)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (in_wait),
        .count (perf_mem_waits)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect),
        .count (perf_flushes)
    );
`else
    assign perf_hazard_stalls = '0;
    assign perf_mem_waits     = '0;
    assign perf_flushes       = '0;
`endif

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb/tb_fetch_stall_ctrl.sv - self-checking bench for fetch_stall_ctrl against a behavioural model
module tb_fetch_stall_ctrl;

    localparam int AW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          pc_stall;
    logic          IF_ID_stall;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] pc;
    logic [31:0]   if_id_instr;
    logic [AW-1:0] if_id_pc_plus4;
    logic          if_id_valid;
    logic [CW-1:0] perf_hazard_stalls;
    logic [CW-1:0] perf_mem_waits;
    logic [CW-1:0] perf_flushes;

    fetch_stall_ctrl_if #(.ADDR_W(AW)) imem_if ();

    fetch_stall_ctrl #(.ADDR_W(AW), .RESET_PC(32'h0), .CNT_W(CW)) dut (
        .clk                (clk),
        .reset              (reset),
        .pc_stall           (pc_stall),
        .IF_ID_stall        (IF_ID_stall),
        .redirect           (redirect),
        .redirect_pc        (redirect_pc),
        .imem               (imem_if),
        .pc                 (pc),
        .if_id_instr        (if_id_instr),
        .if_id_pc_plus4     (if_id_pc_plus4),
        .if_id_valid        (if_id_valid),
        .perf_hazard_stalls (perf_hazard_stalls),
        .perf_mem_waits     (perf_mem_waits),
        .perf_flushes       (perf_flushes)
    );

    always #5 clk = ~clk;

    // Behavioural model: fetch pointer, IF/ID contents, and two flags saying
    // whether a request has been waiting and whether its answer is stale.
    logic [31:0] m_pc, m_instr, m_ppc4;
    logic        m_valid, m_waiting, m_stale;
    int unsigned m_haz, m_mw, m_fl;

    int n_vec  = 0;
    int n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h1234, a[31:16] ^ 16'hBEEF};
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v, input bit inc);
        if (inc && v < 32'd65535) return v + 1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_ppc4 = 32'h0; m_valid = 1'b0;
        m_waiting = 1'b0; m_stale = 1'b0;
        m_haz = 0; m_mw = 0; m_fl = 0;
    endtask

    task automatic compare_all();
        chk("pc", pc, m_pc);
        chk("imem_addr", imem_if.imem_addr, m_pc);
        chk("imem_req", {31'b0, imem_if.imem_req}, {31'b0, !reset});
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc_plus4", if_id_pc_plus4, m_ppc4);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
`ifdef STALL_PERF_CNT_EN
        chk("perf_hazard_stalls", {16'b0, perf_hazard_stalls}, m_haz);
        chk("perf_mem_waits", {16'b0, perf_mem_waits}, m_mw);
        chk("perf_flushes", {16'b0, perf_flushes}, m_fl);
`else
        chk("perf_hazard_stalls", {16'b0, perf_hazard_stalls}, 32'h0);
        chk("perf_mem_waits", {16'b0, perf_mem_waits}, 32'h0);
        chk("perf_flushes", {16'b0, perf_flushes}, 32'h0);
`endif
    endtask

    // Called just after a falling edge; applies one cycle of inputs and
    // compares everything at the next falling edge.
    task automatic step(input bit ps, input bit is, input bit rd, input bit rdy, input logic [31:0] rpc);
        logic [31:0] npc, nin, npp;
        logic        nv, nw, ns, bub;
        pc_stall            = ps;
        IF_ID_stall         = is;
        redirect            = rd;
        redirect_pc         = rpc;
        imem_if.imem_ready  = rdy;
        imem_if.imem_rdata  = rdy ? mem_word(m_pc) : 32'hDEAD_BEEF;
        npc = m_pc; nin = m_instr; npp = m_ppc4; nv = m_valid;
        nw = m_waiting; ns = m_stale; bub = 1'b0;
        if (rd) begin
            npc = rpc;
            bub = 1'b1;
            ns  = (m_waiting || m_stale) && !rdy;
            nw  = 1'b0;
        end else if (m_stale) begin
            if (rdy) ns = 1'b0;
            bub = !is;
        end else if (!rdy) begin
            nw  = 1'b1;
            bub = !is;
        end else begin
            nw = 1'b0;
            if (!ps) npc = m_pc + 32'd4;
            if (!is) begin
                if (ps) bub = 1'b1;
                else begin
                    nin = mem_word(m_pc);
                    npp = m_pc + 32'd4;
                    nv  = 1'b1;
                end
            end
        end
        if (bub) begin
            nin = 32'h0;
            nv  = 1'b0;
        end
        @(posedge clk);
        m_haz = sat_inc(m_haz, ps);
        m_mw  = sat_inc(m_mw, m_waiting || m_stale);
        m_fl  = sat_inc(m_fl, rd);
        m_pc = npc; m_instr = nin; m_ppc4 = npp; m_valid = nv;
        m_waiting = nw; m_stale = ns;
        @(negedge clk);
        n_vec++;
        compare_all();
    endtask

    bit          r_rd, r_rdy, r_ps, r_is;
    int unsigned r_sel;
    logic [31:0] r_pc;

    initial begin
        reset = 1'b1; pc_stall = 1'b0; IF_ID_stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imem_if.imem_ready = 1'b0; imem_if.imem_rdata = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("reset_pc", pc, 32'h0);
        chk("reset_req", {31'b0, imem_if.imem_req}, 32'h0);
        reset = 1'b0;

        for (int k = 1; k <= 2; k++) begin
            step(0, 0, 0, 1, 32'h0);
            chk("adv_ppc4", if_id_pc_plus4, 32'(4 * k));
            chk("adv_instr", if_id_instr, mem_word(32'(4 * (k - 1))));
        end
        for (int k = 0; k < 2; k++) begin
            step(1, 1, 0, 1, 32'h0);
            chk("stall_pc", pc, 32'h8);
            chk("stall_ifid", if_id_instr, mem_word(32'h4));
        end
        step(0, 0, 0, 1, 32'h0);
        chk("release_instr", if_id_instr, mem_word(32'h8));
        chk("release_ppc4", if_id_pc_plus4, 32'hC);
        step(0, 0, 0, 1, 32'h0);
        chk("adv_pc10", pc, 32'h10);

        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 32'h0);
            chk("wait_valid", {31'b0, if_id_valid}, 32'h0);
            chk("wait_instr", if_id_instr, 32'h0);
            chk("wait_pc", pc, 32'h10);
        end
        step(0, 0, 1, 0, 32'h40);
        chk("redir_pc", pc, 32'h40);
`ifdef STALL_PERF_CNT_EN
        chk("perf_waits_lit", {16'b0, perf_mem_waits}, 32'd3);
`endif
        step(0, 0, 0, 1, 32'h0);
        chk("squash_drop_valid", {31'b0, if_id_valid}, 32'h0);
        chk("squash_pc", pc, 32'h40);
        step(0, 0, 0, 1, 32'h0);
        chk("after_squash_instr", if_id_instr, mem_word(32'h40));
        chk("after_squash_ppc4", if_id_pc_plus4, 32'h44);

        step(1, 1, 1, 1, 32'h80);
        chk("redir_win_pc", pc, 32'h80);
        chk("redir_win_valid", {31'b0, if_id_valid}, 32'h0);
`ifdef STALL_PERF_CNT_EN
        chk("perf_flush_lit", {16'b0, perf_flushes}, 32'd2);
`endif

        step(0, 0, 1, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 1, 32'h0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_ppc4", if_id_pc_plus4, 32'h0);
        chk("wrap_instr", if_id_instr, mem_word(32'hFFFF_FFFC));

        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_instr", if_id_instr, 32'h0);
        chk("async_ppc4", if_id_pc_plus4, 32'h0);
        chk("async_valid", {31'b0, if_id_valid}, 32'h0);
        chk("async_req", {31'b0, imem_if.imem_req}, 32'h0);
        chk("async_waits", {16'b0, perf_mem_waits}, 32'h0);
        model_reset();
        @(negedge clk);
        compare_all();
        reset = 1'b0;
        step(0, 0, 0, 1, 32'h0);
        chk("post_reset_ppc4", if_id_pc_plus4, 32'h4);

        for (int i = 0; i < 500; i++) begin
            r_rd  = ($urandom_range(0, 99) < 10);
            r_rdy = ($urandom_range(0, 99) < 70);
            r_sel = $urandom_range(0, 99);
            r_ps  = (r_sel < 20) || (r_sel >= 90 && r_sel < 95);
            r_is  = (r_sel < 20) || (r_sel >= 95);
            r_pc  = $urandom() & 32'hFFFF_FFFC;
            step(r_ps, r_is, r_rd, r_rdy, r_pc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
